// File: rtl/branch_unit_if.sv
// Control-path bundle between the control unit and branch_unit.
// master: control side (drives decoded strobes and ALU flags, observes PC/status).
// slave : branch_unit (consumes strobes, drives PC, flags, branch and status).
interface branch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              pc_en_i;
  logic              flags_we_i;
  logic              alu_z_i;
  logic              alu_c_i;
  logic              alu_n_i;
  logic              alu_v_i;
  logic [3:0]        cond_i;
  logic              ctrl_jmp_i;
  logic              ctrl_call_i;
  logic              ctrl_ret_i;
  logic [ADDR_W-1:0] target_i;
  logic [ADDR_W-1:0] pc_o;
  logic [3:0]        flags_o;
  logic              branch_o;
  logic              stack_full_o;
  logic              stack_empty_o;
  logic              fault_o;

  modport master (
    output pc_en_i, flags_we_i, alu_z_i, alu_c_i, alu_n_i, alu_v_i,
           cond_i, ctrl_jmp_i, ctrl_call_i, ctrl_ret_i, target_i,
    input  pc_o, flags_o, branch_o, stack_full_o, stack_empty_o, fault_o
  );

  modport slave (
    input  pc_en_i, flags_we_i, alu_z_i, alu_c_i, alu_n_i, alu_v_i,
           cond_i, ctrl_jmp_i, ctrl_call_i, ctrl_ret_i, target_i,
    output pc_o, flags_o, branch_o, stack_full_o, stack_empty_o, fault_o
  );
endinterface

// File: rtl/branch_unit.sv
// Branch/sequencing unit: owns the program counter, the {V,N,C,Z} flag
// register and a return-address stack; executes JMP/Jcc, CALL and RET.
// Ports:
//   clk_i  - system clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - branch_unit_if.slave: strobes, ALU flags, condition, target in;
//            pc_o, flags_o, branch_o (combinational), stack status, fault_o out
module branch_unit #(
  parameter int unsigned     ADDR_W      = 8,
  parameter int unsigned     STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  branch_unit_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [3:0]        flags_q;
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic              fault_q, fault_set;
  logic              push, branch;
  logic              stack_full, stack_empty;
  logic              cond_true, multi_strobe;
  logic [IDX_W-1:0]  top_idx, push_idx;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign pc_inc      = pc_q + ADDR_W'(1);
  assign stack_full  = (sp_q == PTR_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign top_idx     = IDX_W'(sp_q - PTR_W'(1));
  assign push_idx    = IDX_W'(sp_q);

  assign multi_strobe = (bus.ctrl_jmp_i  & bus.ctrl_call_i) |
                        (bus.ctrl_jmp_i  & bus.ctrl_ret_i)  |
                        (bus.ctrl_call_i & bus.ctrl_ret_i);

  // Condition evaluation on the registered flags (bit0 Z, bit1 C, bit2 N, bit3 V)
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.cond_i)
      4'b0001: cond_true = 1'b1;
      4'b0010: cond_true = flags_q[0];
      4'b0011: cond_true = ~flags_q[0];
      4'b0100: cond_true = flags_q[1];
      4'b0101: cond_true = ~flags_q[1];
      4'b0110: cond_true = flags_q[2];
      4'b0111: cond_true = ~flags_q[2];
      4'b1000: cond_true = flags_q[3];
      4'b1001: cond_true = ~flags_q[3];
      4'b1010: cond_true = flags_q[2] ^ flags_q[3];
      4'b1011: cond_true = ~(flags_q[2] ^ flags_q[3]);
      4'b1100: cond_true = flags_q[1] | flags_q[0];
      4'b1101: cond_true = ~(flags_q[1] | flags_q[0]);
      default: cond_true = 1'b0;
    endcase
  end

  // Next-PC / stack / fault selection in priority order
  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    push      = 1'b0;
    branch    = 1'b0;
    fault_set = 1'b0;
    if (bus.pc_en_i) begin
      pc_d = pc_inc;
      if (multi_strobe) begin
        fault_set = 1'b1;
      end else if (bus.ctrl_ret_i) begin
        if (!stack_empty) begin
          pc_d   = stack_q[top_idx];
          sp_d   = sp_q - PTR_W'(1);
          branch = 1'b1;
        end else begin
          fault_set = 1'b1;
        end
      end else if (bus.ctrl_call_i) begin
        if (!stack_full) begin
          pc_d   = bus.target_i;
          sp_d   = sp_q + PTR_W'(1);
          push   = 1'b1;
          branch = 1'b1;
        end else begin
          fault_set = 1'b1;
        end
      end else if (bus.ctrl_jmp_i && cond_true) begin
        pc_d   = bus.target_i;
        branch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      fault_q <= 1'b0;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      fault_q <= fault_q | fault_set;
      if (bus.flags_we_i)
        flags_q <= {bus.alu_v_i, bus.alu_n_i, bus.alu_c_i, bus.alu_z_i};
    end
  end

  // Stack storage has no reset; contents are meaningless while empty
  always_ff @(posedge clk_i) begin
    if (push)
      stack_q[push_idx] <= pc_inc;
  end

  assign bus.pc_o          = pc_q;
  assign bus.flags_o       = flags_q;
  assign bus.branch_o      = branch & ~rst_i;
  assign bus.stack_full_o  = stack_full;
  assign bus.stack_empty_o = stack_empty;
  assign bus.fault_o       = fault_q;

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_unit_if #(.ADDR_W(ADDR_W)) bif ();

  branch_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int        m_pc;
  bit [3:0]  m_flags;
  bit        m_fault;
  int        m_stack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input int cond, input bit [3:0] f);
    bit z, c, n, v;
    z = f[0]; c = f[1]; n = f[2]; v = f[3];
    case (cond)
      1:  return 1'b1;
      2:  return z;
      3:  return !z;
      4:  return c;
      5:  return !c;
      6:  return n;
      7:  return !n;
      8:  return v;
      9:  return !v;
      10: return n != v;
      11: return n == v;
      12: return c || z;
      13: return !(c || z);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 0; m_flags = '0; m_fault = 1'b0; m_stack.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pc"},    32'(bif.pc_o),          32'(m_pc));
    check({tag, "_flags"}, 32'(bif.flags_o),       32'(m_flags));
    check({tag, "_full"},  32'(bif.stack_full_o),  32'(m_stack.size() == DEPTH));
    check({tag, "_empty"}, 32'(bif.stack_empty_o), 32'(m_stack.size() == 0));
    check({tag, "_fault"}, 32'(bif.fault_o),       32'(m_fault));
  endtask

  // One cycle: drive, check branch_o mid-cycle, clock, check registered state
  task automatic step(input string tag, input bit en, input bit we, input bit [3:0] alu,
                      input int cond, input bit j, input bit c, input bit r, input int tgt);
    bit br;
    int nxt;
    int n_str;
    bif.pc_en_i = en; bif.flags_we_i = we;
    bif.alu_z_i = alu[0]; bif.alu_c_i = alu[1]; bif.alu_n_i = alu[2]; bif.alu_v_i = alu[3];
    bif.cond_i = 4'(cond); bif.ctrl_jmp_i = j; bif.ctrl_call_i = c; bif.ctrl_ret_i = r;
    bif.target_i = 8'(tgt);
    br = 1'b0;
    nxt = m_pc;
    n_str = int'(j) + int'(c) + int'(r);
    if (en) begin
      nxt = (m_pc + 1) % 256;
      if (n_str > 1) m_fault = 1'b1;
      else if (r) begin
        if (m_stack.size() > 0) begin nxt = m_stack.pop_back(); br = 1'b1; end
        else m_fault = 1'b1;
      end else if (c) begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back((m_pc + 1) % 256); nxt = tgt; br = 1'b1;
        end else m_fault = 1'b1;
      end else if (j && cond_holds(cond, m_flags)) begin
        nxt = tgt; br = 1'b1;
      end
    end
    #1;
    check({tag, "_branch"}, 32'(bif.branch_o), 32'(br));
    @(posedge clk);
    m_pc = nxt;
    if (we) m_flags = alu;
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    bif.pc_en_i = 0; bif.flags_we_i = 0; bif.alu_z_i = 0; bif.alu_c_i = 0;
    bif.alu_n_i = 0; bif.alu_v_i = 0; bif.cond_i = 0; bif.ctrl_jmp_i = 0;
    bif.ctrl_call_i = 0; bif.ctrl_ret_i = 0; bif.target_i = 0;
    model_reset();

    // Reset state, with strobes active to prove branch_o stays low
    bif.pc_en_i = 1; bif.ctrl_jmp_i = 1; bif.cond_i = 4'b0001;
    @(posedge clk); #1;
    check("rst_branch", 32'(bif.branch_o), 32'd0);
    check_state("rst");
    bif.ctrl_jmp_i = 0; bif.cond_i = 0;
    rst = 1'b0;

    // Sequential fetch
    idle("seq1"); idle("seq2"); idle("seq3");
    check("seq_pc3", 32'(bif.pc_o), 32'h03);

    // Wrap 0xFF -> 0x00
    step("jff", 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b0, 1'b0, 8'hFF);
    idle("wrap");
    check("wrap_pc", 32'(bif.pc_o), 32'h00);

    // Flags Z=1,C=0 then jump on Z (taken) and on C (not taken)
    step("wflg", 1'b1, 1'b1, 4'b0001, 0, 1'b0, 1'b0, 1'b0, 0);
    step("jz", 1'b1, 1'b0, 4'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h40);
    check("jz_pc", 32'(bif.pc_o), 32'h40);
    step("jc", 1'b1, 1'b0, 4'h0, 4'b0100, 1'b1, 1'b0, 1'b0, 8'h60);
    check("jc_pc", 32'(bif.pc_o), 32'h41);

    // Same-edge flag write: jump sees old flags
    step("clrf", 1'b1, 1'b1, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 0);
    step("sameedge", 1'b1, 1'b1, 4'b0001, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h30);
    step("nextjz", 1'b1, 1'b0, 4'h0, 4'b0010, 1'b1, 1'b0, 1'b0, 8'h30);
    check("nextjz_pc", 32'(bif.pc_o), 32'h30);

    // pc_en_i low holds everything, flags still load
    step("hold", 1'b0, 1'b1, 4'b1010, 1, 1'b1, 1'b0, 1'b0, 8'h77);

    // Calls to full, overflow, then returns
    step("j10", 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b0, 1'b0, 8'h10);
    for (int i = 0; i < 4; i++) step("call", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 8'h20);
    check("call_full", 32'(bif.stack_full_o), 32'd1);
    step("call5", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 8'h20);
    check("ovf_pc", 32'(bif.pc_o), 32'h21);
    check("ovf_fault", 32'(bif.fault_o), 32'd1);
    for (int i = 0; i < 4; i++) step("ret", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b1, 0);
    check("ret_pc", 32'(bif.pc_o), 32'h11);
    check("ret_empty", 32'(bif.stack_empty_o), 32'd1);

    // Underflow and illegal strobe combination (fresh reset to see the fault set)
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    step("underflow", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b1, 0);
    check("uf_fault", 32'(bif.fault_o), 32'd1);
    step("call1", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 8'h50);
    step("illegal", 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b1, 1'b0, 8'h90);
    check("illegal_pc", 32'(bif.pc_o), 32'h51);

    // Call from 0xFF pushes 0x00
    step("jff2", 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b0, 1'b0, 8'hFF);
    step("callwrap", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 8'h05);
    step("retwrap", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b1, 0);
    check("retwrap_pc", 32'(bif.pc_o), 32'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int sel;
      bit j, c, r;
      sel = $urandom_range(0, 9);
      j = (sel <= 3); c = (sel == 4 || sel == 5); r = (sel == 6 || sel == 7);
      if (sel == 9) begin j = 1'b1; r = $urandom_range(0, 1) == 1; c = !r; end
      step("rnd", $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
           $urandom_range(0, 15), j, c, r, $urandom_range(0, 255));
    end

    // Asynchronous reset between edges after two pushes
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    step("j33", 1'b1, 1'b0, 4'h0, 1, 1'b1, 1'b0, 1'b0, 8'h33);
    step("ret_e", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b0, 1'b1, 0);
    step("p1", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 8'h70);
    step("p2", 1'b1, 1'b0, 4'h0, 0, 1'b0, 1'b1, 1'b0, 8'h80);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_pc", 32'(bif.pc_o), 32'h00);
    check("arst_empty", 32'(bif.stack_empty_o), 32'd1);
    check("arst_fault", 32'(bif.fault_o), 32'd0);
    check("arst_branch", 32'(bif.branch_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle("post_rst");
    check("post_rst_pc", 32'(bif.pc_o), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
